// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: start bit, 5..DBIT_MAX data bits LSB-first,
// optional even/odd parity and 1 or 2 stop bits, timed by an external oversampling tick.
module uart_tx_cfg #(
    parameter int DBIT_MAX   = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tx_start,
    input  logic                s_tick,
    input  logic [DBIT_MAX-1:0] tx_din,
    input  logic [3:0]          cfg_dbits,
    input  logic [1:0]          cfg_parity,
    input  logic                cfg_stop2,
    output logic                tx,
    output logic                tx_busy,
    output logic                tx_done_tick,
    output logic [2:0]          state_out
);

    localparam int SW = $clog2(2 * OVERSAMPLE);
    localparam logic [SW-1:0] S_LAST  = SW'(OVERSAMPLE - 1);
    localparam logic [SW-1:0] S_LAST2 = SW'(2 * OVERSAMPLE - 1);
    localparam logic [3:0]    D_MAX   = 4'(DBIT_MAX);
    localparam logic [3:0]    D_MIN   = 4'd5;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t              state, state_n;
    logic [SW-1:0]       s, s_n;
    logic [3:0]          n, n_n;
    logic [DBIT_MAX-1:0] sh, sh_n;
    logic [3:0]          dbits, dbits_n;
    logic                par_en, par_en_n;
    logic                par_bit, par_bit_n;
    logic                stop2, stop2_n;
    logic                tx_r, tx_n;
    logic                busy_r, busy_n;
    logic                done_r, done_n;

    logic [3:0]          dclamp;
    logic                din_xor;

    // Clamp the requested width and fold the payload parity over the bits actually sent.
    always_comb begin
        dclamp = cfg_dbits;
        if (cfg_dbits < D_MIN)
            dclamp = D_MIN;
        else if (cfg_dbits > D_MAX)
            dclamp = D_MAX;
        din_xor = 1'b0;
        for (int i = 0; i < DBIT_MAX; i++) begin
            if (i < int'(dclamp))
                din_xor = din_xor ^ tx_din[i];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            s       <= '0;
            n       <= '0;
            sh      <= '0;
            dbits   <= '0;
            par_en  <= 1'b0;
            par_bit <= 1'b0;
            stop2   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_n;
            s       <= s_n;
            n       <= n_n;
            sh      <= sh_n;
            dbits   <= dbits_n;
            par_en  <= par_en_n;
            par_bit <= par_bit_n;
            stop2   <= stop2_n;
            tx_r    <= tx_n;
            busy_r  <= busy_n;
            done_r  <= done_n;
        end
    end

    always_comb begin
        state_n   = state;
        s_n       = s;
        n_n       = n;
        sh_n      = sh;
        dbits_n   = dbits;
        par_en_n  = par_en;
        par_bit_n = par_bit;
        stop2_n   = stop2;
        busy_n    = busy_r;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                if (tx_start) begin
                    state_n   = START;
                    s_n       = '0;
                    n_n       = '0;
                    sh_n      = tx_din;
                    dbits_n   = dclamp;
                    par_en_n  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
                    par_bit_n = (cfg_parity == 2'b10) ? ~din_xor : din_xor;
                    stop2_n   = cfg_stop2;
                    busy_n    = 1'b1;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        state_n = DATA;
                        s_n     = '0;
                        n_n     = '0;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        s_n = '0;
                        if (n == dbits - 4'd1) begin
                            state_n = par_en ? PARITY : STOP;
                        end else begin
                            n_n  = n + 4'd1;
                            sh_n = sh >> 1;
                        end
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            PARITY: begin
                if (s_tick) begin
                    if (s == S_LAST) begin
                        state_n = STOP;
                        s_n     = '0;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s == (stop2 ? S_LAST2 : S_LAST)) begin
                        state_n = IDLE;
                        s_n     = '0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                    end else begin
                        s_n = s + SW'(1);
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // tx is registered from the next state so the line changes with the state itself.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = sh_n[0];
            PARITY:  tx_n = par_bit_n;
            default: tx_n = 1'b1;
        endcase
    end

    assign tx           = tx_r;
    assign tx_busy      = busy_r;
    assign tx_done_tick = done_r;
    assign state_out    = state;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Directed bench for uart_tx_cfg: table of frame vectors with hand-computed line
// sequences, plus busy-rejection, back-to-back and mid-frame reset sequences.
module tb_uart_tx_cfg;

    logic       clk = 1'b0;
    logic       reset;
    logic       tx_start;
    logic       s_tick;
    logic [7:0] tx_din;
    logic [3:0] cfg_dbits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       tx;
    logic       tx_busy;
    logic       tx_done_tick;
    logic [2:0] state_out;

    int passed = 0;
    int total  = 0;

    // Tick generator: one s_tick every div clocks, phase restarted by tick_rst.
    int   div      = 1;
    int   tick_cnt = 0;
    logic tick_rst = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tick_rst)
            tick_cnt <= 0;
        else
            tick_cnt <= (tick_cnt == div - 1) ? 0 : tick_cnt + 1;
    end
    assign s_tick = (tick_cnt == div - 1);

    uart_tx_cfg #(.DBIT_MAX(8), .OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .tx_start     (tx_start),
        .s_tick       (s_tick),
        .tx_din       (tx_din),
        .cfg_dbits    (cfg_dbits),
        .cfg_parity   (cfg_parity),
        .cfg_stop2    (cfg_stop2),
        .tx           (tx),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick),
        .state_out    (state_out)
    );

    typedef struct {
        logic [7:0]  din;
        logic [3:0]  dbits;
        logic [1:0]  par;
        logic        stop2;
        int          div;
        int          d;      // effective data bits after clamping
        bit          p;      // parity slot present
        int          nbits;  // bit slots in the frame
        logic [15:0] exp;    // line bits, first transmitted bit leftmost
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act === exp)
            passed++;
        else
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Accepts a frame (or continues one already accepted when pre=1) and samples the
    // line mid-bit, checking state, busy and the done pulse at the frame boundary.
    task automatic run_frame(input vec_t v, input bit pre, input bit hold, input bit poke,
                             input string tag);
        int bitclk, flen, last, k, done_cnt, ks;
        logic [15:0] cap;
        bitclk = 16 * v.div;
        flen   = v.nbits * bitclk;
        last   = hold ? flen : flen + 1;
        if (!pre) begin
            @(negedge clk);
            tx_din     = v.din;
            cfg_dbits  = v.dbits;
            cfg_parity = v.par;
            cfg_stop2  = v.stop2;
            div        = v.div;
            tx_start   = 1'b1;
            tick_rst   = 1'b1;
        end
        @(posedge clk);
        cap      = '0;
        done_cnt = 0;
        for (int j = 0; j <= last; j++) begin
            @(negedge clk);
            if (j == 0) begin
                chk({tag, " start tx"}, {15'd0, tx}, 16'd0);
                chk({tag, " start busy"}, {15'd0, tx_busy}, 16'd1);
                chk({tag, " start state"}, {13'd0, state_out}, 16'd1);
                tx_start = hold;
                tick_rst = 1'b0;
            end
            if (j < flen && tx_done_tick)
                done_cnt++;
            if (j < flen && (j % bitclk) == bitclk / 2) begin
                k   = j / bitclk;
                cap = {cap[14:0], tx};
                if (k == 0)
                    ks = 1;
                else if (k <= v.d)
                    ks = 2;
                else if (k == v.d + 1 && v.p)
                    ks = 3;
                else
                    ks = 4;
                chk($sformatf("%s state slot %0d", tag, k), {13'd0, state_out}, 16'(ks));
            end
            if (j == flen - 1)
                chk({tag, " busy before end"}, {15'd0, tx_busy}, 16'd1);
            if (j == flen) begin
                chk({tag, " line bits"}, cap, v.exp);
                chk({tag, " early done"}, 16'(done_cnt), 16'd0);
                chk({tag, " done"}, {15'd0, tx_done_tick}, 16'd1);
                chk({tag, " busy at done"}, {15'd0, tx_busy}, 16'd0);
                chk({tag, " idle at done"}, {13'd0, state_out}, 16'd0);
                chk({tag, " tx at done"}, {15'd0, tx}, 16'd1);
                if (hold)
                    tick_rst = 1'b1;
            end
            if (j == flen + 1) begin
                chk({tag, " done width"}, {15'd0, tx_done_tick}, 16'd0);
                chk({tag, " no requeue"}, {15'd0, tx_busy}, 16'd0);
                chk({tag, " tx idle"}, {15'd0, tx}, 16'd1);
            end
            if (poke && j == 40) begin
                tx_start   = 1'b1;
                tx_din     = 8'h00;
                cfg_dbits  = 4'd5;
                cfg_parity = 2'b01;
            end
            if (poke && j == 41)
                tx_start = hold;
        end
    endtask

    initial begin
        int dn;
        vt[0] = '{8'hA5, 4'd8,  2'b00, 1'b0, 1, 8, 1'b0, 10, 16'b0_10100101_1};
        vt[1] = '{8'hFF, 4'd7,  2'b01, 1'b1, 1, 7, 1'b1, 11, 16'b0_1111111_1_11};
        vt[2] = '{8'h03, 4'd5,  2'b10, 1'b0, 4, 5, 1'b1, 8,  16'b0_11000_1_1};
        vt[3] = '{8'h13, 4'd2,  2'b00, 1'b0, 1, 5, 1'b0, 7,  16'b0_11001_1};
        vt[4] = '{8'h3C, 4'd15, 2'b10, 1'b0, 1, 8, 1'b1, 11, 16'b0_00111100_1_1};
        vt[5] = '{8'hEA, 4'd6,  2'b11, 1'b1, 1, 6, 1'b0, 9,  16'b0_010101_11};

        reset      = 1'b1;
        tx_start   = 1'b0;
        tx_din     = '0;
        cfg_dbits  = 4'd8;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset tx", {15'd0, tx}, 16'd1);
        chk("reset busy", {15'd0, tx_busy}, 16'd0);
        chk("reset done", {15'd0, tx_done_tick}, 16'd0);
        chk("reset state", {13'd0, state_out}, 16'd0);

        for (int i = 0; i < 6; i++)
            run_frame(vt[i], 1'b0, 1'b0, 1'b0, $sformatf("vec%0d", i));

        // Mid-frame start request and config change must not disturb the frame.
        run_frame(vt[0], 1'b0, 1'b0, 1'b1, "busy_reject");

        // tx_start held high: next START one clock after the done pulse.
        run_frame(vt[3], 1'b0, 1'b1, 1'b0, "b2b_first");
        run_frame(vt[3], 1'b1, 1'b0, 1'b0, "b2b_second");

        // Reset in the middle of DATA aborts the frame silently.
        @(negedge clk);
        tx_din     = 8'hA5;
        cfg_dbits  = 4'd8;
        cfg_parity = 2'b00;
        cfg_stop2  = 1'b0;
        div        = 1;
        tx_start   = 1'b1;
        tick_rst   = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        tick_rst = 1'b0;
        repeat (39) @(negedge clk);
        chk("pre-reset state", {13'd0, state_out}, 16'd2);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort tx", {15'd0, tx}, 16'd1);
        chk("abort busy", {15'd0, tx_busy}, 16'd0);
        chk("abort state", {13'd0, state_out}, 16'd0);
        chk("abort done", {15'd0, tx_done_tick}, 16'd0);
        dn = 0;
        repeat (200) begin
            @(negedge clk);
            if (tx_done_tick || tx_busy || !tx)
                dn++;
        end
        chk("abort quiet line", 16'(dn), 16'd0);
        run_frame(vt[0], 1'b0, 1'b0, 1'b0, "after_reset");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
